// File: rtl/complex_butterfly_pipe_pkg.sv
// Shared definitions for the radix-2 butterfly datapath.
//   N_DEF / TW_DEF : default data and twiddle widths
//   round_k        : half-LSB rounding constant used before dropping TW-1 fraction bits
//   sat_n          : clip a wide signed value into the signed n-bit range
package complex_butterfly_pipe_pkg;

   localparam int unsigned N_DEF  = 16;
   localparam int unsigned TW_DEF = 16;

   function automatic logic signed [63:0] round_k(input int unsigned tw);
      return 64'sd1 <<< (tw - 2);
   endfunction

   function automatic logic signed [63:0] sat_n(input logic signed [63:0] v,
                                                input int unsigned        n);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (n - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (n - 1));
      if (v > max_v)      return max_v;
      else if (v < min_v) return min_v;
      else                return v;
   endfunction

endpackage

// File: rtl/complex_butterfly_pipe_mult.sv
// cmplx_mult_round: two-stage complex multiply B*W with round-half-up.
//   clk, rst (async, active high), ce (stall)
//   b_re/b_im : N-bit signed operand, w_re/w_im : TW-bit signed twiddle
//   p_re/p_im : N+1-bit signed rounded product, valid 2 enabled cycles later
module cmplx_mult_round
   import complex_butterfly_pipe_pkg::*;
#(
   parameter int unsigned N  = N_DEF,
   parameter int unsigned TW = TW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ce,
   input  logic signed [N-1:0]  b_re,
   input  logic signed [N-1:0]  b_im,
   input  logic signed [TW-1:0] w_re,
   input  logic signed [TW-1:0] w_im,
   output logic signed [N:0]    p_re,
   output logic signed [N:0]    p_im
);

   localparam int unsigned PW = N + TW;
   localparam int unsigned SW = N + TW + 1;
   localparam logic signed [SW-1:0] RND = SW'(round_k(TW));

   logic signed [PW-1:0] rr;
   logic signed [PW-1:0] ii;
   logic signed [PW-1:0] ri;
   logic signed [PW-1:0] ir;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr   <= '0;
         ii   <= '0;
         ri   <= '0;
         ir   <= '0;
         p_re <= '0;
         p_im <= '0;
      end else if (ce) begin
         rr   <= b_re * w_re;
         ii   <= b_im * w_im;
         ri   <= b_re * w_im;
         ir   <= b_im * w_re;
         // Full-width sum, round, then keep N+1 bits of the shifted result.
         p_re <= (N+1)'((SW'(rr) - SW'(ii) + RND) >>> (TW - 1));
         p_im <= (N+1)'((SW'(ri) + SW'(ir) + RND) >>> (TW - 1));
      end
   end

endmodule

// File: rtl/complex_butterfly_pipe.sv
// complex_butterfly_pipe: 3-stage radix-2 DIT butterfly, X = A + W*B, Y = A - W*B.
//   i_clk, i_rst (async, active high), i_ce (freezes whole pipeline)
//   i_valid, i_scale  : sample tag and per-sample divide-by-2 select
//   i_Are/i_Aim, i_Bre/i_Bim (N bits), i_Wre/i_Wim (TW bits), all signed
//   i_ovf_clr         : synchronous clear of o_ovf, independent of i_ce
//   o_valid, o_X_re/o_X_im, o_Y_re/o_Y_im : results 3 enabled cycles after input
//   o_ovf             : sticky saturation flag
module complex_butterfly_pipe
   import complex_butterfly_pipe_pkg::*;
#(
   parameter int unsigned N  = N_DEF,
   parameter int unsigned TW = TW_DEF
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_ce,
   input  logic                 i_valid,
   input  logic                 i_scale,
   input  logic signed [N-1:0]  i_Are,
   input  logic signed [N-1:0]  i_Aim,
   input  logic signed [N-1:0]  i_Bre,
   input  logic signed [N-1:0]  i_Bim,
   input  logic signed [TW-1:0] i_Wre,
   input  logic signed [TW-1:0] i_Wim,
   input  logic                 i_ovf_clr,
   output logic                 o_valid,
   output logic signed [N-1:0]  o_X_re,
   output logic signed [N-1:0]  o_X_im,
   output logic signed [N-1:0]  o_Y_re,
   output logic signed [N-1:0]  o_Y_im,
   output logic                 o_ovf
);

   localparam logic signed [N+1:0] ONE = (N+2)'(1);

   logic signed [N-1:0] a_re1, a_im1, a_re2, a_im2;
   logic                v1, v2, s1, s2;
   logic signed [N:0]   p_re, p_im;
   logic [N:0]          xr_s, xi_s, yr_s, yi_s;
   logic                any_sat;

   cmplx_mult_round #(.N(N), .TW(TW)) u_mult (
      .clk  (i_clk),
      .rst  (i_rst),
      .ce   (i_ce),
      .b_re (i_Bre),
      .b_im (i_Bim),
      .w_re (i_Wre),
      .w_im (i_Wim),
      .p_re (p_re),
      .p_im (p_im)
   );

   function automatic logic signed [N+1:0] scl(input logic signed [N+1:0] v,
                                               input logic               s);
      return s ? ((v + ONE) >>> 1) : v;
   endfunction

   // Returns {saturated_flag, clipped N-bit value}.
   function automatic logic [N:0] sat_pack(input logic signed [N+1:0] v);
      logic signed [63:0] w;
      logic signed [63:0] c;
      w = 64'(v);
      c = sat_n(w, N);
      return {c != w, c[N-1:0]};
   endfunction

   always_comb begin
      xr_s    = sat_pack(scl((N+2)'(a_re2) + (N+2)'(p_re), s2));
      xi_s    = sat_pack(scl((N+2)'(a_im2) + (N+2)'(p_im), s2));
      yr_s    = sat_pack(scl((N+2)'(a_re2) - (N+2)'(p_re), s2));
      yi_s    = sat_pack(scl((N+2)'(a_im2) - (N+2)'(p_im), s2));
      any_sat = xr_s[N] | xi_s[N] | yr_s[N] | yi_s[N];
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         a_re1   <= '0;
         a_im1   <= '0;
         a_re2   <= '0;
         a_im2   <= '0;
         v1      <= 1'b0;
         v2      <= 1'b0;
         s1      <= 1'b0;
         s2      <= 1'b0;
         o_valid <= 1'b0;
         o_X_re  <= '0;
         o_X_im  <= '0;
         o_Y_re  <= '0;
         o_Y_im  <= '0;
      end else if (i_ce) begin
         a_re1   <= i_Are;
         a_im1   <= i_Aim;
         a_re2   <= a_re1;
         a_im2   <= a_im1;
         v1      <= i_valid;
         v2      <= v1;
         s1      <= i_scale;
         s2      <= s1;
         o_valid <= v2;
         o_X_re  <= xr_s[N-1:0];
         o_X_im  <= xi_s[N-1:0];
         o_Y_re  <= yr_s[N-1:0];
         o_Y_im  <= yi_s[N-1:0];
      end
   end

   // A new saturating result outranks a simultaneous clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                      o_ovf <= 1'b0;
      else if (i_ce && v2 && any_sat) o_ovf <= 1'b1;
      else if (i_ovf_clr)             o_ovf <= 1'b0;
   end

endmodule

// File: tb/tb_complex_butterfly_pipe.sv
module tb_complex_butterfly_pipe;

   logic        i_clk = 1'b0;
   logic        i_rst, i_ce, i_valid, i_scale, i_ovf_clr;
   logic [15:0] i_Are, i_Aim, i_Bre, i_Bim, i_Wre, i_Wim;
   logic        o_valid, o_ovf;
   logic [15:0] o_X_re, o_X_im, o_Y_re, o_Y_im;

   always #5 i_clk = ~i_clk;

   complex_butterfly_pipe #(.N(16), .TW(16)) dut (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_ce      (i_ce),
      .i_valid   (i_valid),
      .i_scale   (i_scale),
      .i_Are     (i_Are),
      .i_Aim     (i_Aim),
      .i_Bre     (i_Bre),
      .i_Bim     (i_Bim),
      .i_Wre     (i_Wre),
      .i_Wim     (i_Wim),
      .i_ovf_clr (i_ovf_clr),
      .o_valid   (o_valid),
      .o_X_re    (o_X_re),
      .o_X_im    (o_X_im),
      .o_Y_re    (o_Y_re),
      .o_Y_im    (o_Y_im),
      .o_ovf     (o_ovf)
   );

   typedef struct {
      logic [15:0] xr, xi, yr, yi;
      bit          sat;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   bit   vp0, vp1, exp_valid, exp_ovf;
   int   checks = 0;
   int   errors = 0;
   int   dut_cnt;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic longint wrap17(input longint v);
      longint t;
      t = (v + 65536) & 131071;
      return t - 65536;
   endfunction

   function automatic longint scl_sat(input longint v, input bit sc, output bit s);
      longint r;
      r = sc ? ((v + 1) >>> 1) : v;
      s = 1'b0;
      if (r > 32767) begin r = 32767; s = 1'b1; end
      else if (r < -32768) begin r = -32768; s = 1'b1; end
      return r;
   endfunction

   function automatic exp_t model(input logic signed [15:0] ar, ai, br, bi, wr, wi,
                                  input bit sc);
      exp_t   e;
      longint pr, pi, xr, xi, yr, yi;
      bit     s0, s1, s2, s3;
      pr = longint'(br) * longint'(wr) - longint'(bi) * longint'(wi);
      pi = longint'(br) * longint'(wi) + longint'(bi) * longint'(wr);
      pr = wrap17((pr + 16384) >>> 15);
      pi = wrap17((pi + 16384) >>> 15);
      xr = scl_sat(longint'(ar) + pr, sc, s0);
      xi = scl_sat(longint'(ai) + pi, sc, s1);
      yr = scl_sat(longint'(ar) - pr, sc, s2);
      yi = scl_sat(longint'(ai) - pi, sc, s3);
      e.xr = xr[15:0];
      e.xi = xi[15:0];
      e.yr = yr[15:0];
      e.yi = yi[15:0];
      e.sat = s0 | s1 | s2 | s3;
      return e;
   endfunction

   // Called at a negedge: drive, advance the reference at the posedge, check at the next negedge.
   task automatic step(input bit v, input bit sc,
                       input logic [15:0] ar, ai, br, bi, wr, wi,
                       input bit ce, input bit clr);
      bit setov;
      i_valid = v; i_scale = sc; i_ce = ce; i_ovf_clr = clr;
      i_Are = ar; i_Aim = ai; i_Bre = br; i_Bim = bi; i_Wre = wr; i_Wim = wi;
      @(posedge i_clk);
      setov = 1'b0;
      if (ce) begin
         exp_valid = vp1;
         vp1 = vp0;
         vp0 = v;
         if (v) q.push_back(model(ar, ai, br, bi, wr, wi, sc));
         if (exp_valid) begin
            if (q.size() > 0) cur = q.pop_front();
            setov = cur.sat;
         end
      end
      if (setov) exp_ovf = 1'b1;
      else if (clr) exp_ovf = 1'b0;
      @(negedge i_clk);
      if (ce && o_valid) dut_cnt++;
      chk("valid", {15'd0, o_valid}, {15'd0, exp_valid});
      chk("ovf", {15'd0, o_ovf}, {15'd0, exp_ovf});
      if (exp_valid) begin
         chk("x_re", o_X_re, cur.xr);
         chk("x_im", o_X_im, cur.xi);
         chk("y_re", o_Y_re, cur.yr);
         chk("y_im", o_Y_im, cur.yi);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b0);
   endtask

   function automatic logic [15:0] pick();
      int unsigned r;
      r = $urandom_range(0, 7);
      if (r == 0) return 16'h8000;
      if (r == 1) return 16'h7FFF;
      return 16'($urandom);
   endfunction

   initial begin
      i_rst = 1'b1; i_ce = 1'b1; i_valid = 1'b0; i_scale = 1'b0; i_ovf_clr = 1'b0;
      i_Are = '0; i_Aim = '0; i_Bre = '0; i_Bim = '0; i_Wre = '0; i_Wim = '0;
      vp0 = 0; vp1 = 0; exp_valid = 0; exp_ovf = 0; dut_cnt = 0;
      #1;
      chk("rst_valid", {15'd0, o_valid}, 16'd0);
      chk("rst_ovf", {15'd0, o_ovf}, 16'd0);
      chk("rst_xre", o_X_re, 16'h0000);
      @(negedge i_clk);
      i_rst = 1'b0;

      // 1: scaled real butterfly
      step(1'b1, 1'b1, 16'h2000, 16'h0000, 16'h4000, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
      idle(2);
      chk("t1_valid", {15'd0, o_valid}, 16'd1);
      chk("t1_xre", o_X_re, 16'h3000);
      chk("t1_yre", o_Y_re, 16'hF000);
      chk("t1_xim", o_X_im, 16'h0000);
      chk("t1_yim", o_Y_im, 16'h0000);
      chk("t1_ovf", {15'd0, o_ovf}, 16'd0);

      // 2: W = -j (Wim = -1)
      step(1'b1, 1'b1, 16'h0000, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h8000, 1'b1, 1'b0);
      idle(2);
      chk("t2_xim", o_X_im, 16'hE000);
      chk("t2_yim", o_Y_im, 16'h2000);
      chk("t2_xre", o_X_re, 16'h0000);
      chk("t2_yre", o_Y_re, 16'h0000);

      // 3: saturation, sticky flag, clear, then set-beats-clear
      step(1'b1, 1'b0, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
      idle(2);
      chk("t3_xre", o_X_re, 16'h7FFF);
      chk("t3_yre", o_Y_re, 16'h0001);
      chk("t3_ovf", {15'd0, o_ovf}, 16'd1);
      step(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b1);
      chk("t3_ovf_clr", {15'd0, o_ovf}, 16'd0);
      step(1'b1, 1'b0, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
      idle(1);
      step(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b1);
      chk("t3_set_wins", {15'd0, o_ovf}, 16'd1);
      step(1'b0, 1'b0, '0, '0, '0, '0, '0, '0, 1'b1, 1'b1);
      idle(2);

      // 4: 8-sample stream with a 2-cycle stall in the middle
      dut_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         if (k == 4 || k == 5)
            step(1'b1, 1'b0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 1'b0, 1'b0);
         else
            step(1'b1, k[0], 16'(k * 16'h0900), 16'(16'hF000 + k * 16'h0301),
                 16'(16'h4000 - k * 16'h0777), 16'(k * 16'h0555),
                 16'(16'h5A82 + k * 16'h0100), 16'(16'hA57E - k * 16'h0123), 1'b1, 1'b0);
      end
      idle(3);
      chk("t4_count", 16'(dut_cnt), 16'd8);
      chk("t4_drained", 16'(q.size()), 16'd0);

      // 5: reset with two samples in flight
      step(1'b1, 1'b0, 16'h1234, 16'h4321, 16'h2000, 16'h1000, 16'h7FFF, 16'h0000, 1'b1, 1'b0);
      step(1'b1, 1'b1, 16'h0100, 16'h0200, 16'h3000, 16'h0400, 16'h4000, 16'h4000, 1'b1, 1'b0);
      i_rst = 1'b1;
      #1;
      chk("t5_valid", {15'd0, o_valid}, 16'd0);
      chk("t5_xre", o_X_re, 16'h0000);
      chk("t5_yim", o_Y_im, 16'h0000);
      q.delete();
      vp0 = 0; vp1 = 0; exp_valid = 0; exp_ovf = 0;
      @(negedge i_clk);
      i_rst = 1'b0;
      idle(5);

      // 6: random traffic with stalls, clears and extreme operands
      for (int k = 0; k < 10000; k++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              pick(), pick(), pick(), pick(), pick(), pick(),
              $urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0);
      idle(4);
      chk("t6_drained", 16'(q.size()), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
